// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: tag-space defaults, the reserved NO_TAG value and the
// allocator FSM state type. The reservation stations and the CDB import these as well.
package tomasulo_pkg;

   localparam int unsigned TAG_WIDTH_DEFAULT  = 4;
   localparam int unsigned FIFO_DEPTH_DEFAULT = 4;

   // Tag 0 means "operand ready" and is never allocated.
   localparam int unsigned NO_TAG = 0;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } alloc_state_t;

endpackage

// File: rtl/free_tag_encoder.sv
// Lowest-set-bit finder: reports whether any bit of free_vec is set and the index of the
// lowest one. Purely combinational.
module free_tag_encoder #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0] free_vec,
   output logic             found,
   output logic [IDX_W-1:0] index
);

   // Scan from the top down so the last hit, i.e. the lowest set bit, wins.
   always_comb begin
      found = 1'b0;
      index = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (free_vec[i]) begin
            found = 1'b1;
            index = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/tag_issue_allocator.sv
// Issue-side tag allocator. Hands out the lowest free reservation-station tag, pushes it
// into the in-order tag FIFO, frees tags on CDB broadcasts, gates retire pops against the
// tracked FIFO occupancy and drains the FIFO after a flush.
module tag_issue_allocator
   import tomasulo_pkg::*;
#(
   parameter int unsigned TAG_WIDTH  = TAG_WIDTH_DEFAULT,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
   localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 issue_req,
   output logic                 issue_grant,
   output logic [TAG_WIDTH-1:0] issue_tag,
   output logic                 fifo_push,
   output logic [TAG_WIDTH-1:0] fifo_push_tag,
   input  logic                 retire_req,
   output logic                 fifo_pop,
   input  logic                 cdb_valid,
   input  logic [TAG_WIDTH-1:0] cdb_tag,
   input  logic                 flush,
   output logic [CNT_W-1:0]     fifo_count,
   output logic                 fifo_full,
   output logic                 fifo_empty,
   output logic [TAG_WIDTH-1:0] free_count,
   output logic                 release_err,
   output logic                 draining
);

   localparam int unsigned NUM_TAGS = 2 ** TAG_WIDTH;

   logic [NUM_TAGS-1:1] busy_q, busy_d;
   logic [CNT_W-1:0]    fifo_count_q, fifo_count_d;
   alloc_state_t        state_q, state_d;
   logic                release_err_q, release_err_d;

   logic                 tag_found;
   logic [TAG_WIDTH-1:0] lowest_free;
   logic                 cdb_hits_busy;

   // Bit 0 (NO_TAG) is presented as never free so it can't be picked.
   free_tag_encoder #(
      .WIDTH (NUM_TAGS),
      .IDX_W (TAG_WIDTH)
   ) u_free_tag_encoder (
      .free_vec ({~busy_q, 1'b0}),
      .found    (tag_found),
      .index    (lowest_free)
   );

   assign fifo_count = fifo_count_q;
   assign fifo_full  = (fifo_count_q == CNT_W'(FIFO_DEPTH));
   assign fifo_empty = (fifo_count_q == '0);
   assign draining   = (state_q == DRAIN);
   assign release_err = release_err_q;

   // Grant and pop gating; full blocks a grant even when a pop happens this cycle.
   always_comb begin
      issue_grant = 1'b0;
      fifo_pop    = 1'b0;
      if (state_q == IDLE) begin
         issue_grant = issue_req & ~flush & tag_found & ~fifo_full;
         fifo_pop    = retire_req & ~fifo_empty;
      end else begin
         fifo_pop    = ~fifo_empty;
      end
      issue_tag     = issue_grant ? lowest_free : TAG_WIDTH'(NO_TAG);
      fifo_push     = issue_grant;
      fifo_push_tag = issue_tag;
   end

   // Population count of free tags, taken from registered state only.
   always_comb begin
      free_count = '0;
      for (int i = 1; i < NUM_TAGS; i++) begin
         free_count = free_count + {{(TAG_WIDTH - 1){1'b0}}, ~busy_q[i]};
      end
   end

   // Next-state for busy bitmap, FIFO occupancy, FSM and sticky release error.
   always_comb begin
      busy_d        = busy_q;
      fifo_count_d  = fifo_count_q;
      state_d       = state_q;
      release_err_d = release_err_q;
      cdb_hits_busy = (cdb_tag != TAG_WIDTH'(NO_TAG)) && busy_q[cdb_tag];

      // CDB releases only count outside DRAIN.
      if (state_q == IDLE && cdb_valid) begin
         if (cdb_hits_busy) begin
            busy_d[cdb_tag] = 1'b0;
         end else begin
            release_err_d = 1'b1;
         end
      end
      // Applied after the release so a set on the same tag wins.
      if (issue_grant) begin
         busy_d[issue_tag] = 1'b1;
      end

      unique case ({fifo_push, fifo_pop})
         2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
         2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
         default: fifo_count_d = fifo_count_q;
      endcase

      if (flush) begin
         busy_d  = '0;
         state_d = (fifo_count_d != '0) ? DRAIN : IDLE;
      end else if (state_q == DRAIN && fifo_count_d == '0) begin
         state_d = IDLE;
      end
   end

   // All allocator state; FIFO receives the same asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q        <= '0;
         fifo_count_q  <= '0;
         state_q       <= IDLE;
         release_err_q <= 1'b0;
      end else begin
         busy_q        <= busy_d;
         fifo_count_q  <= fifo_count_d;
         state_q       <= state_d;
         release_err_q <= release_err_d;
      end
   end

endmodule

// File: doc/tag_issue_allocator.md
# tag_issue_allocator

Issue-side allocator that owns the reservation-station tag space and feeds the in-order tag FIFO. It hands out the lowest free tag on each accepted issue request and pushes that tag into the order FIFO in the same cycle. It frees tags on CDB broadcasts and gates retire-side pops so the FIFO, which has no full/empty flags of its own, never overflows or underflows. On flush it clears the busy state and drains the FIFO back to empty.

## Interface
- TAG_WIDTH, 4, tag width; tag 0 is reserved as NO_TAG (operand ready), so allocatable tags are 1..2^TAG_WIDTH-1
- FIFO_DEPTH, 4, depth of the downstream order FIFO; must be a power of two ≥ 2
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- issue_req  in  1  decode requests a tag this cycle
- issue_grant  out  1  request accepted this cycle (combinational)
- issue_tag  out  TAG_WIDTH  granted tag; NO_TAG when issue_grant=0
- fifo_push  out  1  push strobe to the order FIFO; equals issue_grant
- fifo_push_tag  out  TAG_WIDTH  equals issue_tag
- retire_req  in  1  consumer wants to pop the FIFO front
- fifo_pop  out  1  gated pop strobe to the order FIFO
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_WIDTH  broadcast tag to free
- flush  in  1  mispredict/exception flush, one-cycle pulse
- fifo_count  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy
- fifo_full, fifo_empty  out  1  derived from fifo_count
- free_count  out  TAG_WIDTH  number of free tags
- release_err  out  1  sticky: CDB freed a tag that was not busy, or freed NO_TAG
- draining  out  1  high while in DRAIN state

## Operation
- State: busy[2^TAG_WIDTH-1:1] bitmap, fifo_count, FSM {IDLE, DRAIN}, release_err.
- Reset: busy=0, fifo_count=0, FSM=IDLE, release_err=0. Outputs after reset: issue_grant=0, fifo_pop=0, free_count=2^TAG_WIDTH-1, fifo_empty=1, fifo_full=0, draining=0.
- Grant in IDLE: issue_grant = issue_req & ~flush & any free tag & ~fifo_full. issue_tag is the lowest-index free tag from the registered bitmap. busy[issue_tag] sets at the next edge.
- Full blocks a grant even if a pop occurs in the same cycle. This is conservative and has no combinational pop→grant path.
- Release: if cdb_valid and busy[cdb_tag], that bit clears at the edge. If cdb_tag=0 or the bit is already clear, nothing changes and release_err sets.
- A tag freed in cycle N is grantable from cycle N+1, never in cycle N. If a grant and a release hit the same tag in one cycle, which only happens on an error release, the set wins.
- Pop: fifo_pop = retire_req & ~fifo_empty in IDLE. If the FIFO is empty, retire_req is ignored.
- fifo_count: +1 on push only, −1 on pop only, unchanged on both or neither. It saturates logically, and the gating guarantees bounds.
- Flush (any state): at the edge busy is cleared and FSM goes to DRAIN if fifo_count≠0 after that edge's push/pop update. Otherwise FSM stays in or returns to IDLE. No grant in the flush cycle.
- DRAIN: issue_grant=0. fifo_pop=1 every cycle regardless of retire_req. CDB releases are ignored, with no release_err. At the edge where fifo_count goes 1→0, return to IDLE.
- A flush during DRAIN restarts the same behaviour; busy is already clear.

## Timing
- Grant/push is combinational from issue_req. The FIFO captures push_tag at the same rising edge at which busy is set.
- Pop is combinational from retire_req. The FIFO head advances on that edge, and fifo_count updates on the same edge.
- Drain latency is exactly fifo_count cycles after the flush edge.
- free_count and fifo_count are registered-derived, with no input combinational paths.
- Asynchronous reset applies mid-DRAIN or mid-operation with no residual state. The FIFO receives the same reset.

## Structure
- Shared package tomasulo_pkg holds TAG_WIDTH default, the NO_TAG=0 constant, and the alloc_state_t enum {IDLE, DRAIN}. The reservation stations and CDB already consume these.
- One sub-module: free_tag_encoder. It is a combinational lowest-set-bit finder over ~busy that outputs found and index. Popcount for free_count lives in the top.

## Test plan
- Reset, then 4 issue_req cycles with TAG_WIDTH=4, FIFO_DEPTH=4 → tags 1,2,3,4 granted and pushed, fifo_full=1. The 5th request gets issue_grant=0 and issue_tag=0.
- CDB frees tag 2 while the FIFO is full and retire_req=1 pops once. In the same cycle issue_req is blocked. Next cycle it is granted tag 2, and fifo_count returns to 4.
- Fill 15 tags with retire keeping pace → free_count=0 and the 16th request is denied. cdb_tag=7 releases it, and the next grant is tag 7.
- retire_req with the FIFO empty → fifo_pop=0, fifo_count stays 0. cdb_tag=5 while not busy → release_err=1, sticky until reset.
- 3 entries queued, then flush plus issue_req in the same cycle → no grant, busy=0, draining=1 with fifo_pop high for exactly 3 cycles. The FSM returns to IDLE, and the next grant is tag 1.
- Assert reset mid-DRAIN → all outputs return to reset values immediately, and fifo_pop=0.
